// File: rtl/hood_fan_timer.sv
// Range-hood fan timer: runtime accumulator, boost countdown with limited uses, BCD display word.
// Optional clean reminder is compiled in with `define HOOD_CLEAN_REMINDER_EN.
module hood_fan_timer #(
  parameter int unsigned BOOST_CODE   = 3,
  parameter int unsigned BOOST_MIN    = 1,
  parameter int unsigned BOOST_SEC    = 0,
  parameter int unsigned BOOST_USES   = 1,
  parameter int unsigned RETURN_LEVEL = 2,
  parameter int unsigned HOUR_MAX     = 24,
  parameter int unsigned CLEAN_HOURS  = 10
) (
  input  logic        clk_1hz,
  input  logic        rst,
  input  logic [2:0]  mode,
  input  logic        menu_req,
  input  logic        runtime_clr,
  output logic [31:0] display_data,
  output logic        boost_active,
  output logic        boost_done,
  output logic        boost_denied,
  output logic [2:0]  return_mode,
  output logic [3:0]  uses_left,
  output logic        clean_reminder
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_BOOST = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [5:0] cd_min_q, cd_min_d, cd_sec_q, cd_sec_d;
  logic [6:0] rt_hr_q, rt_hr_d;
  logic [5:0] rt_min_q, rt_min_d, rt_sec_q, rt_sec_d;
  logic [3:0] uses_q, uses_d;
  logic [2:0] ret_q, ret_d;
  logic       active_q, active_d, done_q, done_d, denied_q, denied_d;
  logic       menu_seen_q, menu_seen_d;
  logic       is_boost, is_run, accum, sec_roll, min_roll, hr_wrap;
  logic [1:0] idle_or_run;
  logic [3:0] sep_hi;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  assign is_boost    = (mode == 3'(BOOST_CODE));
  assign is_run      = (mode != 3'd0) && (mode < 3'(BOOST_CODE));
  assign idle_or_run = is_run ? S_RUN : S_IDLE;

  always_comb begin
    state_d     = state_q;
    cd_min_d    = cd_min_q;
    cd_sec_d    = cd_sec_q;
    uses_d      = uses_q;
    ret_d       = ret_q;
    active_d    = active_q;
    menu_seen_d = menu_seen_q;
    done_d      = 1'b0;
    denied_d    = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (is_boost) begin
          if (uses_q != 4'd0) begin
            state_d     = S_BOOST;
            cd_min_d    = 6'(BOOST_MIN);
            cd_sec_d    = 6'(BOOST_SEC);
            menu_seen_d = 1'b0;
            active_d    = 1'b1;
          end else begin
            state_d  = S_IDLE;
            denied_d = 1'b1;
          end
        end else begin
          state_d = idle_or_run;
        end
      end
      S_BOOST: begin
        if (!is_boost) begin
          // Abort still spends the use but leaves return_mode alone.
          uses_d   = uses_q - 4'd1;
          active_d = 1'b0;
          state_d  = idle_or_run;
        end else if (cd_min_q == 6'd0 && cd_sec_q == 6'd0) begin
          done_d      = 1'b1;
          uses_d      = uses_q - 4'd1;
          menu_seen_d = menu_seen_q | menu_req;
          ret_d       = (menu_seen_q || menu_req) ? 3'd0 : 3'(RETURN_LEVEL);
          active_d    = 1'b0;
          state_d     = S_HOLD;
        end else begin
          menu_seen_d = menu_seen_q | menu_req;
          if (cd_sec_q == 6'd0) begin
            cd_sec_d = 6'd59;
            cd_min_d = cd_min_q - 6'd1;
          end else begin
            cd_sec_d = cd_sec_q - 6'd1;
          end
        end
      end
      default: begin
        if (!is_boost) state_d = idle_or_run;
      end
    endcase
  end

  // Runtime counts on the edge that lands in RUN/BOOST, so the first running edge is counted.
  assign accum    = (state_d == S_RUN) || (state_d == S_BOOST);
  assign sec_roll = (rt_sec_q == 6'd59);
  assign min_roll = sec_roll && (rt_min_q == 6'd59);
  assign hr_wrap  = min_roll && (rt_hr_q == 7'(HOUR_MAX - 1));

  always_comb begin
    rt_hr_d  = rt_hr_q;
    rt_min_d = rt_min_q;
    rt_sec_d = rt_sec_q;
    if (runtime_clr) begin
      rt_hr_d  = 7'd0;
      rt_min_d = 6'd0;
      rt_sec_d = 6'd0;
    end else if (accum) begin
      rt_sec_d = sec_roll ? 6'd0 : rt_sec_q + 6'd1;
      if (sec_roll) rt_min_d = min_roll ? 6'd0 : rt_min_q + 6'd1;
      if (min_roll) rt_hr_d = hr_wrap ? 7'd0 : rt_hr_q + 7'd1;
    end
  end

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cd_min_q    <= 6'(BOOST_MIN);
      cd_sec_q    <= 6'(BOOST_SEC);
      uses_q      <= 4'(BOOST_USES);
      ret_q       <= 3'(RETURN_LEVEL);
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      denied_q    <= 1'b0;
      menu_seen_q <= 1'b0;
      rt_hr_q     <= 7'd0;
      rt_min_q    <= 6'd0;
      rt_sec_q    <= 6'd0;
    end else begin
      state_q     <= state_d;
      cd_min_q    <= cd_min_d;
      cd_sec_q    <= cd_sec_d;
      uses_q      <= uses_d;
      ret_q       <= ret_d;
      active_q    <= active_d;
      done_q      <= done_d;
      denied_q    <= denied_d;
      menu_seen_q <= menu_seen_d;
      rt_hr_q     <= rt_hr_d;
      rt_min_q    <= rt_min_d;
      rt_sec_q    <= rt_sec_d;
    end
  end

`ifdef HOOD_CLEAN_REMINDER_EN
  logic clean_q, clean_d, clean_hit;

  always_comb begin
    if (CLEAN_HOURS >= HOUR_MAX) clean_hit = hr_wrap;
    else                         clean_hit = min_roll && (rt_hr_q == 7'(CLEAN_HOURS - 1));
    clean_d = runtime_clr ? 1'b0 : (clean_q | (accum & clean_hit));
  end

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) clean_q <= 1'b0;
    else      clean_q <= clean_d;
  end

  assign clean_reminder = clean_q;
  assign sep_hi         = (clean_q && !active_q) ? 4'hC : 4'hF;
`else
  assign clean_reminder = 1'b0;
  assign sep_hi         = 4'hF;
`endif

  always_comb begin
    if (active_q) begin
      display_data = {8'h00, 4'hF, to_bcd({1'b0, cd_min_q}), 4'hF, to_bcd({1'b0, cd_sec_q})};
    end else begin
      display_data = {to_bcd(rt_hr_q), sep_hi, to_bcd({1'b0, rt_min_q}), 4'hF,
                      to_bcd({1'b0, rt_sec_q})};
    end
  end

  assign boost_active = active_q;
  assign boost_done   = done_q;
  assign boost_denied = denied_q;
  assign return_mode  = ret_q;
  assign uses_left    = uses_q;

endmodule

// File: tb/tb_hood_fan_timer.sv
// Directed bench for hood_fan_timer: a default instance plus a two-use, two-hour-wrap instance.
module tb_hood_fan_timer;

`ifdef HOOD_CLEAN_REMINDER_EN
  localparam bit CLEAN_ON = 1'b1;
`else
  localparam bit CLEAN_ON = 1'b0;
`endif

  logic        clk_1hz, rst;
  logic [2:0]  mode_a, mode_b;
  logic        menu_a, menu_b, clr_a, clr_b;
  logic [31:0] disp_a, disp_b;
  logic        act_a, act_b, done_a, done_b, den_a, den_b, cln_a, cln_b;
  logic [2:0]  ret_a, ret_b;
  logic [3:0]  uses_a, uses_b;

  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int rt_a  = 0;
  int rt_b  = 0;

  hood_fan_timer dut_a (
    .clk_1hz(clk_1hz), .rst(rst), .mode(mode_a), .menu_req(menu_a), .runtime_clr(clr_a),
    .display_data(disp_a), .boost_active(act_a), .boost_done(done_a), .boost_denied(den_a),
    .return_mode(ret_a), .uses_left(uses_a), .clean_reminder(cln_a)
  );

  hood_fan_timer #(.BOOST_USES(2), .HOUR_MAX(2), .CLEAN_HOURS(1)) dut_b (
    .clk_1hz(clk_1hz), .rst(rst), .mode(mode_b), .menu_req(menu_b), .runtime_clr(clr_b),
    .display_data(disp_b), .boost_active(act_b), .boost_done(done_b), .boost_denied(den_b),
    .return_mode(ret_b), .uses_left(uses_b), .clean_reminder(cln_b)
  );

  // clock / reset
  initial clk_1hz = 1'b0;
  always #5 clk_1hz = ~clk_1hz;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // reference formatting, computed from plain second counts
  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] rt_word(input int s, input int hr_max, input bit cln);
    return {bcd2((s / 3600) % hr_max), cln ? 4'hC : 4'hF, bcd2((s / 60) % 60), 4'hF, bcd2(s % 60)};
  endfunction

  function automatic logic [31:0] cd_word(input int s);
    return {8'h00, 4'hF, bcd2(s / 60), 4'hF, bcd2(s % 60)};
  endfunction

  // driver tasks: each tick passes n rising edges and returns on the following falling edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk_1hz);
    @(negedge clk_1hz);
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    mode_a = 3'd0; mode_b = 3'd0;
    menu_a = 1'b0; menu_b = 1'b0;
    clr_a = 1'b0;  clr_b = 1'b0;
    tick(2);

    // reset values
    push(32'h00F00F00); check("rst_disp_a", disp_a);
    push(32'd1);        check("rst_uses_a", 32'(uses_a));
    push(32'd2);        check("rst_ret_a", 32'(ret_a));
    push(32'd0);        check("rst_flags_a", {28'd0, act_a, done_a, den_a, cln_a});
    push(32'd2);        check("rst_uses_b", 32'(uses_b));
    rst = 1'b1;

    // runtime accumulation and hold
    mode_a = 3'd1; push(32'h01F02F05); tick(3725); rt_a = 3725; check("run_3725", disp_a);
    mode_a = 3'd0; push(32'h01F02F05); tick(10); check("idle_hold", disp_a);

    // boost on default instance, no menu press
    mode_a = 3'd3; tick(1); rt_a++;
    push(32'd1);       check("boost_act", 32'(act_a));
    push(cd_word(60)); check("boost_cd_60", disp_a);
    tick(1); rt_a++;
    push(cd_word(59)); check("boost_cd_59", disp_a);
    tick(59); rt_a += 59;
    push(32'd0);       check("boost_not_done", 32'(done_a));
    push(cd_word(0));  check("boost_cd_0", disp_a);
    tick(1);
    push(32'd1); check("boost_done", 32'(done_a));
    push(32'd0); check("boost_act_off", 32'(act_a));
    push(32'd2); check("boost_ret", 32'(ret_a));
    push(32'd0); check("boost_uses", 32'(uses_a));
    push(rt_word(rt_a, 24, 1'b0)); check("boost_rt", disp_a);
    tick(1);
    push(32'd0); check("done_pulse", 32'(done_a));
    push(rt_word(rt_a, 24, 1'b0)); check("hold_rt", disp_a);

    // denied boost: 3 -> 2 -> 3 with no uses left
    mode_a = 3'd2; tick(1); rt_a++;
    push(rt_word(rt_a, 24, 1'b0)); check("hold_to_run", disp_a);
    mode_a = 3'd3; tick(1);
    push(32'd1); check("denied", 32'(den_a));
    push(32'd0); check("denied_act", 32'(act_a));
    tick(3);
    push(rt_word(rt_a, 24, 1'b0)); check("denied_frozen", disp_a);
    mode_a = 3'd0; tick(1);
    push(32'd0); check("denied_clear", 32'(den_a));

    // two-use instance: abort at 00:40
    mode_b = 3'd3; tick(1); rt_b++;
    push(cd_word(60)); check("b_entry", disp_b);
    tick(20); rt_b += 20;
    push(cd_word(40)); check("b_cd_40", disp_b);
    mode_b = 3'd1; tick(1); rt_b++;
    push(32'd0); check("abort_done", 32'(done_b));
    push(32'd0); check("abort_act", 32'(act_b));
    push(32'd1); check("abort_uses", 32'(uses_b));
    push(32'd2); check("abort_ret", 32'(ret_b));
    tick(5); rt_b += 5;
    push(rt_word(rt_b, 2, 1'b0)); check("abort_rt", disp_b);

    // second boost, menu pressed at 00:30
    mode_b = 3'd3; tick(1); rt_b++;
    push(cd_word(60)); check("b2_entry", disp_b);
    tick(30); rt_b += 30;
    push(cd_word(30)); check("b2_cd_30", disp_b);
    menu_b = 1'b1; tick(1); rt_b++; menu_b = 1'b0;
    tick(29); rt_b += 29;
    push(cd_word(0)); check("b2_cd_0", disp_b);
    tick(1);
    push(32'd1); check("b2_done", 32'(done_b));
    push(32'd0); check("b2_ret_menu", 32'(ret_b));
    push(32'd0); check("b2_uses", 32'(uses_b));

    // hour boundary, clean reminder, wrap at HOUR_MAX=2
    mode_b = 3'd1; tick(3600 - rt_b); rt_b = 3600;
    push(32'(CLEAN_ON)); check("clean_flag", 32'(cln_b));
    push(rt_word(rt_b, 2, CLEAN_ON)); check("clean_disp", disp_b);
    tick(3598); rt_b += 3598;
    push(32'h01F59F58 ^ (CLEAN_ON ? 32'h00300000 : 32'h0)); check("pre_wrap", disp_b);
    tick(2); rt_b += 2;
    push(rt_word(rt_b, 2, CLEAN_ON)); check("wrap", disp_b);
    tick(5);
    clr_b = 1'b1; tick(1); clr_b = 1'b0; mode_b = 3'd0; rt_b = 0;
    push(32'h00F00F00); check("clr_disp", disp_b);
    push(32'd0);        check("clr_flag", 32'(cln_b));
    push(32'd0);        check("a_clean_never", 32'(cln_a));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
